// File: rtl/core_lsu_pkg.sv
// ============================================================================
// Module      : core_lsu_pkg
// Description : Shared core constants (ALU opcodes, LSU sizes, LSU states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_lsu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam logic [1:0] LSU_SIZE_X = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_REQ    = 2'd1,
        LSU_WAIT_R = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_e;

    // Illegal size or an address not naturally aligned to the access size.
    function automatic logic lsu_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = addr_lo[0];
            LSU_SIZE_W: bad = |addr_lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_lsu_if.sv
// ============================================================================
// Module      : core_lsu_if
// Description : Execute-stage request, memory bus and response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // master: the LSU itself; slave: execute stage plus memory
    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  resp_valid, resp_rdata, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/core_lsu_align.sv
// ============================================================================
// Module      : core_lsu_align
// Description : Store lane steering and load lane extraction / extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_lsu_align
    import core_lsu_pkg::*;
(
    input  wire logic [1:0]  i_st_size,
    input  wire logic [1:0]  i_st_addr_lo,
    input  wire logic [31:0] i_st_wdata,
    output logic      [3:0]  o_st_be,
    output logic      [31:0] o_st_wdata,
    input  wire logic [1:0]  i_ld_size,
    input  wire logic [1:0]  i_ld_addr_lo,
    input  wire logic        i_ld_unsigned,
    input  wire logic [31:0] i_ld_rdata,
    output logic      [31:0] o_ld_data
);

    logic [31:0] w_lane;
    logic        w_sign;

    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            LSU_SIZE_B: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                o_st_be    = 4'b0011 << i_st_addr_lo;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_lane    = i_ld_rdata >> {i_ld_addr_lo, 3'b000};
        w_sign    = 1'b0;
        o_ld_data = w_lane;
        case (i_ld_size)
            LSU_SIZE_B: begin
                w_sign    = ~i_ld_unsigned & w_lane[7];
                o_ld_data = {{24{w_sign}}, w_lane[7:0]};
            end
            LSU_SIZE_H: begin
                w_sign    = ~i_ld_unsigned & w_lane[15];
                o_ld_data = {{16{w_sign}}, w_lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/core_lsu.sv
// ============================================================================
// Module      : core_lsu
// Description : Single-outstanding load/store unit with alignment check and read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    core_lsu_if.master  bus
);

    localparam logic [7:0] C_WAIT_LAST = 8'(WAIT_MAX - 1);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_cnt;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_illegal;
    logic        w_timeout;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    core_lsu_align u_align (
        .i_st_size     (bus.req_size),
        .i_st_addr_lo  (bus.req_addr[1:0]),
        .i_st_wdata    (bus.req_wdata),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_addr_lo  (r_addr_lo),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (bus.mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    assign w_illegal = lsu_illegal(bus.req_size, bus.req_addr[1:0]);
    assign w_timeout = (r_cnt == C_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= LSU_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                w_req_ready = 1'b1;
                w_accept    = bus.req_valid;
                if (bus.req_valid) w_state_nxt = w_illegal ? LSU_RESP : LSU_REQ;
            end
            LSU_REQ: begin
                if (bus.mem_gnt) w_state_nxt = r_we ? LSU_RESP : LSU_WAIT_R;
            end
            LSU_WAIT_R: begin
                if (bus.mem_rvalid || w_timeout) w_state_nxt = LSU_RESP;
            end
            LSU_RESP: w_state_nxt = LSU_IDLE;
            default:  w_state_nxt = LSU_IDLE;
        endcase
    end

    // Memory-side fields are captured at accept so they cannot change under a stalled grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_size       <= LSU_SIZE_B;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_cnt        <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_be     <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_we       <= bus.req_we;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_addr_lo  <= bus.req_addr[1:0];
                        if (w_illegal) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_be    <= w_st_be;
                            r_mem_wdata <= w_st_wdata;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.mem_gnt) begin
                        r_mem_req    <= 1'b0;
                        r_cnt        <= 8'd0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                    end
                end
                LSU_WAIT_R: begin
                    if (bus.mem_rvalid) begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_ld_data;
                    end else if (w_timeout) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.resp_valid = (r_state == LSU_RESP);
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have parameter: WAIT_MAX, default 255, max cycles from grant to mem_rvalid before a load times out (1..255).
REQ-002 SHALL have port: clk  input  1  single rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  execute stage presents an access.
REQ-005 SHALL have port: req_ready  output  1  LSU accepts an access this cycle.
REQ-006 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 SHALL have port: req_unsigned  input  1  zero-extend load data (LBU/LHU).
REQ-009 SHALL have port: req_addr  input  32  byte address, taken from the ALU add result.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: mem_req  output  1  memory request, held until mem_gnt.
REQ-012 SHALL have port: mem_we  output  1  memory write.
REQ-013 SHALL have port: mem_addr  output  32  word address, bits [1:0]=0.
REQ-014 SHALL have port: mem_be  output  4  byte-lane enables.
REQ-015 SHALL have port: mem_wdata  output  32  lane-steered store data.
REQ-016 SHALL have port: mem_gnt  input  1  memory accepts the request.
REQ-017 SHALL have port: mem_rvalid  input  1  read data valid.
REQ-018 SHALL have port: mem_rdata  input  32  read word.
REQ-019 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-020 SHALL have port: resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-021 SHALL have port: resp_err  output  1  misaligned, illegal size, or timeout; qualified by resp_valid.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, WAIT_R, RESP; req_ready=1 only in IDLE.
REQ-023 SHALL accept on req_valid&&req_ready, registering all request fields; the registered copy is the only source for later cycles.
REQ-024 SHALL treat size 3, half with addr[0]=1, or word with addr[1:0]!=0 as error: IDLE->RESP, resp_err=1, mem_req never asserted.
REQ-025 SHALL, for a legal access, go IDLE->REQ; mem_req, mem_we, mem_addr, mem_be, mem_wdata are registered and stable while in REQ.
REQ-026 SHALL set mem_be to 0001<<a[1:0] for byte, 0011<<a[1:0] for half, 1111 for word; mem_wdata is wdata replicated per lane (byte x4, half x2).
REQ-027 SHALL on mem_gnt in REQ: store -> RESP; load -> WAIT_R with wait counter cleared.
REQ-028 SHALL in WAIT_R: on mem_rvalid, capture the lane selected by addr[1:0], sign- or zero-extend per req_unsigned, -> RESP; mem_rvalid outside WAIT_R is ignored.
REQ-029 SHALL increment the 8-bit wait counter each WAIT_R cycle without mem_rvalid; on reaching WAIT_MAX, -> RESP with resp_err=1 and resp_rdata=0; mem_rvalid in the same cycle takes priority (no error).
REQ-030 SHALL assert resp_valid for exactly one cycle in RESP, then -> IDLE; minimum latency is accept -> resp_valid 2 cycles (store granted immediately), 3 for a load with rvalid the cycle after grant.
REQ-031 SHALL never issue a second mem_req before the current access's resp_valid.

Reset
REQ-032 SHALL on rst_n=0 at a clock edge enter IDLE; mem_req, mem_we, resp_valid, resp_err=0; mem_addr, mem_be, mem_wdata, resp_rdata, wait counter=0; req_ready=1 in the cycle after.
REQ-033 SHALL abandon any in-flight access on reset without a response; a later mem_rvalid is ignored.

Structure
REQ-034 SHALL take size encodings (LSU_SIZE_B/H/W) and state encodings from the shared core constants package used by the ALU opcodes.
REQ-035 SHALL place lane steering (mem_be, mem_wdata) and load extraction/extension in one combinational sub-module core_lsu_align; the FSM and counter stay in core_lsu.

Verification
REQ-036 SHALL cover: SW addr 0x104 wdata 0xDEADBEEF, gnt same cycle -> mem_be=1111, mem_addr=0x104, resp_valid 2 cycles after accept, err=0.
REQ-037 SHALL cover: LB addr 0x203, mem_rdata 0x80FF_FF00 -> resp_rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 SHALL cover: SH addr 0x202 wdata 0x1234 -> mem_be=1100, mem_wdata=0x1234_1234; LW addr 0x102 -> resp_err=1, mem_req never asserted.
REQ-039 SHALL cover: LW with gnt delayed 3 cycles and WAIT_MAX=4 with no rvalid -> mem_req held 3 cycles with constant fields, resp_err=1 after 4 WAIT_R cycles.
REQ-040 SHALL cover: rst_n=0 while in WAIT_R, then mem_rvalid -> no resp_valid, req_ready=1, next LW completes normally.
